// File: rtl/risk_tile_agu.sv
// Strided tile address generator: one SZ-lane address row per beat, SZ beats per tile.
// Row 0 appears the cycle after accept; rows hold stable while out_ready is low.
module risk_tile_agu #(
  parameter int SZ = 4,
  parameter int AW = 15,
  parameter int SW = 14,
  parameter int RW = (SZ > 1) ? $clog2(SZ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [AW-1:0]    base_addr,
  input  logic [SW-1:0]    stride_x,
  input  logic [SW-1:0]    stride_y,
  input  logic             transpose,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SZ*AW-1:0] out_addrs,
  output logic [RW-1:0]    out_row,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ls_q, rs_q;
  logic [AW-1:0] ls_in, rs_in;
  logic [AW-1:0] lane_q    [SZ];
  logic [AW-1:0] lane_init [SZ];
  logic [AW-1:0] acc;
  logic [RW-1:0] row_q;
  logic          accept, advance, last_row;

  assign ls_in    = transpose ? AW'(stride_y) : AW'(stride_x);
  assign rs_in    = transpose ? AW'(stride_x) : AW'(stride_y);
  assign accept   = (state == IDLE) && start_valid;
  // abort beats a simultaneous handshake: the pending row is dropped
  assign advance  = (state == RUN) && out_ready && !abort;
  assign last_row = (row_q == RW'(SZ - 1));

  // Row 0 lanes built as a running sum so no multiplier sits on the accept path
  always_comb begin
    acc = base_addr;
    for (int i = 0; i < SZ; i++) begin
      lane_init[i] = acc;
      acc          = acc + ls_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_valid) state_nxt = RUN;
      RUN: begin
        if (abort)                      state_nxt = IDLE;
        else if (out_ready && last_row) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SZ; i++) lane_q[i] <= '0;
      row_q <= '0;
      ls_q  <= '0;
      rs_q  <= '0;
    end else if (accept) begin
      lane_q <= lane_init;
      row_q  <= '0;
      ls_q   <= ls_in;
      rs_q   <= rs_in;
    end else if (advance) begin
      for (int i = 0; i < SZ; i++) lane_q[i] <= lane_q[i] + rs_q;
      row_q <= row_q + RW'(1);
    end
  end

  for (genvar g = 0; g < SZ; g++) begin : g_lane
    assign out_addrs[g*AW +: AW] = lane_q[g];
  end

  assign out_valid   = (state == RUN);
  assign out_last    = out_valid && last_row;
  assign out_row     = row_q;
  assign busy        = (state != IDLE);
  assign start_ready = (state == IDLE);

endmodule
